// File: rtl/usb_rx_byte_fifo.sv
// usb_rx_byte_fifo
// Receive-side byte buffer between the FT232H USB block and fabric consumers
// such as the LED display and the command decoder. The USB block signals each
// new byte with a rising edge on byte_received, and this FIFO turns every such
// edge into exactly one push. Bytes are stored until a consumer pops them.
// Everything runs on CLOCK_50 in one clock domain.
module usb_rx_byte_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              byte_received,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clr_overflow
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    // Storage array. It is never reset, because stale contents cannot be
    // observed once both pointers and the count have been cleared.
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Registered state and the next value of each register
    logic              br_q;
    logic [ADDR_W-1:0] wrPtr_q,     wrPtr_d;
    logic [ADDR_W-1:0] rdPtr_q,     rdPtr_d;
    logic [ADDR_W:0]   count_q,     count_d;
    logic [DATA_W-1:0] dout_q,      dout_d;
    logic              doutValid_q, doutValid_d;
    logic              overflow_q,  overflow_d;

    // Decoded events for the current cycle
    logic pushReq;
    logic popOk;
    logic pushOk;
    logic dropByte;

    // Both flags come only from the count register, so they are glitch-free.
    assign empty      = (count_q == '0);
    assign full       = (count_q == DEPTH_CNT);
    assign count      = count_q;
    assign dout       = dout_q;
    assign dout_valid = doutValid_q;
    assign overflow   = overflow_q;

    // Decodes the push and pop events. When the FIFO is full, a pop in the
    // same cycle frees a slot, so a coincident push is accepted and not dropped.
    always_comb begin
        pushReq  = byte_received & ~br_q;
        popOk    = rd_en & ~empty;
        pushOk   = pushReq & (~full | popOk);
        dropByte = pushReq & full & ~popOk;
    end

    // Computes the next pointers, count, output byte and overflow flag.
    // There is no bypass path: a byte pushed into an empty FIFO can be read
    // in the following cycle at the earliest.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        dout_d      = dout_q;
        doutValid_d = 1'b0;
        overflow_d  = overflow_q;

        if (pushOk) begin
            wrPtr_d = wrPtr_q + ADDR_W'(1);
        end

        if (popOk) begin
            rdPtr_d     = rdPtr_q + ADDR_W'(1);
            dout_d      = mem_q[rdPtr_q];
            doutValid_d = 1'b1;
        end

        if (pushOk && !popOk) begin
            count_d = count_q + (ADDR_W + 1)'(1);
        end else if (popOk && !pushOk) begin
            count_d = count_q - (ADDR_W + 1)'(1);
        end

        // A drop in the same cycle as a clear leaves the flag set, so the
        // drop is never lost.
        if (dropByte) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // Control registers with synchronous reset. The edge register resets to 1
    // so that a byte_received level held high through reset is not taken as a
    // new byte. Reset overrides any rd_en that arrives in the same cycle.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            br_q        <= 1'b1;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            doutValid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            br_q        <= byte_received;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            doutValid_q <= doutValid_d;
            overflow_q  <= overflow_d;
        end
    end

    // Writes accepted bytes into storage. Writes are gated by reset so a byte
    // arriving during reset leaves the array untouched.
    always_ff @(posedge CLOCK_50) begin
        if (reset_n && pushOk) begin
            mem_q[wrPtr_q] <= rx_data;
        end
    end

endmodule
